// File: rtl/bits4_pkg.sv
// Shared types and widths for the 4-bit adder/subtractor result path.
package bits4_pkg;

  localparam int RES_W  = 5;
  localparam int OP_W   = 4;
  localparam int STAT_W = 8;

  typedef struct packed {
    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] diff;
  } res_pair_t;

endpackage

// File: rtl/bits4_sat_counter.sv
// Saturating up-counter used for the optional result statistics.
module bits4_sat_counter
  import bits4_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count accepted events, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/bits4_result_buffer.sv
// Result FIFO for the bits4 adder/subtractor pair with a valid/ready output.
// The producer cannot stall, so writes offered while full are dropped and
// recorded in a sticky overflow flag.
// Optional macro ADDSUB_STATS_EN adds carry_cnt / neg_cnt statistics.
module bits4_result_buffer
  import bits4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_W = bits4_pkg::RES_W,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_sum,
  input  logic [RES_W-1:0] in_diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_sum,
  output logic [RES_W-1:0] out_diff,
  output logic [LVL_W-1:0] level,
`ifdef ADDSUB_STATS_EN
  output logic [STAT_W-1:0] carry_cnt,
  output logic [STAT_W-1:0] neg_cnt,
`endif
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [RES_W-1:0] mem_sum  [DEPTH];
  logic [RES_W-1:0] mem_diff [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Full/empty come from the occupancy count; pointers wrap freely.
  always_comb begin
    in_ready  = (level != LVL_W'(DEPTH));
    out_valid = (level != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    drop      = in_valid & ~in_ready;
  end

  // Head entry is read straight from storage, forced to zero when empty.
  always_comb begin
    out_sum  = '0;
    out_diff = '0;
    if (out_valid) begin
      out_sum  = mem_sum[rd_ptr];
      out_diff = mem_diff[rd_ptr];
    end
  end

  // Storage array needs no reset; entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr]  <= in_sum;
      mem_diff[wr_ptr] <= in_diff;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef ADDSUB_STATS_EN
  bits4_sat_counter #(.W(STAT_W)) u_carry_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (push & in_sum[RES_W-1]),
    .count (carry_cnt)
  );

  bits4_sat_counter #(.W(STAT_W)) u_neg_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (push & in_diff[RES_W-1]),
    .count (neg_cnt)
  );
`endif

endmodule

// File: tb/tb_bits4_result_buffer.sv
// Directed bench for bits4_result_buffer (DEPTH = 4).
module tb_bits4_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_sum;
  logic [4:0] in_diff;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;
  logic [4:0] out_diff;
  logic [2:0] level;
  logic       overflow;
`ifdef ADDSUB_STATS_EN
  logic [7:0] carry_cnt;
  logic [7:0] neg_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [4:0] fs [4] = '{5'b01100, 5'b01101, 5'b00011, 5'b01110};
  logic [4:0] fd [4] = '{5'b10100, 5'b11011, 5'b00001, 5'b01000};

  always #5 clk = ~clk;

  bits4_result_buffer #(.DEPTH(4), .RES_W(5), .LVL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_diff   (in_diff),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .level     (level),
`ifdef ADDSUB_STATS_EN
    .carry_cnt (carry_cnt),
    .neg_cnt   (neg_cnt),
`endif
    .overflow  (overflow)
  );

  function automatic logic [4:0] ps(input int k);
    return 5'(k + 3);
  endfunction

  function automatic logic [4:0] pd(input int k);
    return 5'(31 - k);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [4:0] s, input logic [4:0] d);
    in_valid = 1'b1;
    in_sum   = s;
    in_diff  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_diff = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    check("rst_level", 16'(level), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_sum", 16'(out_sum), 16'd0);
    check("rst_out_diff", 16'(out_diff), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);

    // Single push, visible one cycle later
    push_one(5'b10000, 5'b11100);
    check("p1_out_valid", 16'(out_valid), 16'd1);
    check("p1_out_sum", 16'(out_sum), 16'b10000);
    check("p1_out_diff", 16'(out_diff), 16'b11100);
    check("p1_level", 16'(level), 16'd1);

    // Pop back to empty: outputs forced to zero
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("pop1_level", 16'(level), 16'd0);
    check("pop1_out_valid", 16'(out_valid), 16'd0);
    check("pop1_out_sum", 16'(out_sum), 16'd0);
    check("pop1_out_diff", 16'(out_diff), 16'd0);

    // Fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      push_one(fs[i], fd[i]);
      check("fill_level", 16'(level), 16'(i + 1));
    end
    check("full_in_ready", 16'(in_ready), 16'd0);
    check("full_out_valid", 16'(out_valid), 16'd1);

    // Dropped write while full
    in_sum = 5'b00000; in_diff = 5'b11111; in_valid = 1'b1;
    check("pre_drop_overflow", 16'(overflow), 16'd0);
    cyc();
    in_valid = 1'b0;
    check("drop_overflow", 16'(overflow), 16'd1);
    check("drop_level", 16'(level), 16'd4);
    check("drop_head_sum", 16'(out_sum), 16'(fs[0]));

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_sum", 16'(out_sum), 16'(fs[i]));
      check("drain_diff", 16'(out_diff), 16'(fd[i]));
      cyc();
    end
    out_ready = 1'b0;
    check("drain_level", 16'(level), 16'd0);
    check("drain_out_valid", 16'(out_valid), 16'd0);
    check("drain_overflow_sticky", 16'(overflow), 16'd1);

    // Simultaneous push/pop at level 2 across pointer wrap
    push_one(ps(0), pd(0));
    push_one(ps(1), pd(1));
    check("sim_start_level", 16'(level), 16'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_sum   = ps(k + 2);
      in_diff  = pd(k + 2);
      check("sim_head_sum", 16'(out_sum), 16'(ps(k)));
      check("sim_head_diff", 16'(out_diff), 16'(pd(k)));
      cyc();
      check("sim_level", 16'(level), 16'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("sim_end_head", 16'(out_sum), 16'(ps(6)));

    // Refill to full, then pop with a refused push in the same cycle
    push_one(ps(8), pd(8));
    push_one(ps(9), pd(9));
    check("refull_level", 16'(level), 16'd4);
    check("refull_in_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b1; in_sum = 5'b11111; in_diff = 5'b11111; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpop_level", 16'(level), 16'd3);
    check("fullpop_head_sum", 16'(out_sum), 16'(ps(7)));
    check("fullpop_in_ready", 16'(in_ready), 16'd1);

    // Reset mid-stream with a push offered
    rst = 1'b1; in_valid = 1'b1; in_sum = ps(10); in_diff = pd(10);
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_level", 16'(level), 16'd0);
    check("midrst_out_valid", 16'(out_valid), 16'd0);
    check("midrst_overflow", 16'(overflow), 16'd0);
    check("midrst_in_ready", 16'(in_ready), 16'd1);
    check("midrst_out_sum", 16'(out_sum), 16'd0);

`ifdef ADDSUB_STATS_EN
    check("stat_rst_carry", 16'(carry_cnt), 16'd0);
    check("stat_rst_neg", 16'(neg_cnt), 16'd0);
    out_ready = 1'b1;
    push_one(5'b10000, 5'b11100);
    for (int i = 0; i < 4; i++) push_one(fs[i], fd[i]);
    check("stat_carry5", 16'(carry_cnt), 16'd1);
    check("stat_neg5", 16'(neg_cnt), 16'd3);
    for (int i = 0; i < 300; i++) push_one(5'b10000, 5'b11100);
    check("stat_carry_sat", 16'(carry_cnt), 16'd255);
    check("stat_neg_sat", 16'(neg_cnt), 16'd255);
    out_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
